// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes instructions, resolves EX forwarding and buffers
// decoded operations in a two-entry skid FIFO feeding the ALU.
module alu_issue_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [1:0]  ALUOp,
    output logic [4:0]  rd,
    output logic [7:0]  illegal_cnt
);

    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } entry_t;

    entry_t           fifo_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       illegal_cnt_q;

    logic [3:0]  opcode;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [15:0] imm;
    logic        legal;
    logic        use_imm;
    logic [31:0] imm_ext;
    logic [31:0] a_val;
    logic [31:0] rt_val;
    entry_t      new_entry;
    logic        accept;
    logic        push;
    logic        pop;

    assign opcode = instr[31:28];
    assign rs_f   = instr[22:18];
    assign rt_f   = instr[17:13];
    assign imm    = instr[15:0];

    // Opcode decode: ALU op and B-operand source
    always_comb begin
        legal     = 1'b1;
        use_imm   = 1'b0;
        imm_ext   = 32'd0;
        new_entry = '0;
        case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3: new_entry.op = opcode[1:0];
            4'd4: begin
                new_entry.op = 2'b00;
                use_imm      = 1'b1;
                imm_ext      = {{16{imm[15]}}, imm};
            end
            4'd5: begin
                new_entry.op = 2'b01;
                use_imm      = 1'b1;
                imm_ext      = {16'd0, imm};
            end
            default: legal = 1'b0;
        endcase
        new_entry.a  = a_val;
        new_entry.b  = use_imm ? imm_ext : rt_val;
        new_entry.rd = instr[27:23];
    end

    // EX-stage forwarding; register 0 is never forwarded
    assign a_val  = (fwd_valid && (fwd_rd == rs_f) && (rs_f != 5'd0)) ? fwd_data : rs_data;
    assign rt_val = (fwd_valid && (fwd_rd == rt_f) && (rt_f != 5'd0)) ? fwd_data : rt_data;

    assign out_valid = (count_q != '0);
    assign in_ready  = !flush && ((count_q < CNT_W'(DEPTH)) || (out_valid && out_ready));
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready && !flush;

    assign A     = fifo_q[rd_ptr_q].a;
    assign B     = fifo_q[rd_ptr_q].b;
    assign ALUOp = fifo_q[rd_ptr_q].op;
    assign rd    = fifo_q[rd_ptr_q].rd;
    assign illegal_cnt = illegal_cnt_q;

    // FIFO storage, pointers, occupancy and illegal-opcode counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= '0;
            illegal_cnt_q <= 8'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= new_entry;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (accept && !legal && (illegal_cnt_q != 8'hFF)) begin
                illegal_cnt_q <= illegal_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions push expected
// ALU operations; a monitor compares them as the DUT issues.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  ALUOp;
    logic [4:0]  rd;
    logic [7:0]  illegal_cnt;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t expq[$];
    int   vectors;
    int   miscompares;
    bit   saw_valid;

    alu_issue_stage #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALUOp(ALUOp), .rd(rd), .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [3:0] op, input logic [4:0] d,
                                         input logic [4:0] s, input logic [4:0] t);
        return {op, d, s, t, 13'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [3:0] op, input logic [4:0] d,
                                         input logic [4:0] s, input logic [15:0] im);
        return {op, d, s, 2'b00, im};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every retiring head must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_issue: got A=0x%08h rd=%0d expected nothing", A, rd);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("issue_op", 32'(ALUOp), 32'(e.op));
                chk("issue_a", A, e.a);
                chk("issue_b", B, e.b);
                chk("issue_rd", 32'(rd), 32'(e.rd));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high
    task automatic send(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd,
                        input bit legal, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        instr    = ins;
        rs_data  = rsd;
        rt_data  = rtd;
        #3;
        while (!in_ready && n < 20) begin
            @(posedge clk); #4;
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end else if (legal) begin
            expq.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0; flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_a", A, 32'd0);
        chk("reset_b", B, 32'd0);
        chk("reset_aluop", 32'(ALUOp), 32'd0);
        chk("reset_rd", 32'(rd), 32'd0);
        chk("reset_illegal_cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // ADD with next-cycle latency
        send(mk_r(4'd0, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 1'b1, exp_t'{2'b00, 32'd5, 32'd7, 5'd3});
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        idle(2);

        // Immediate forms, NAND, forwarding on A and B
        send(mk_i(4'd4, 5'd6, 5'd1, 16'hFFFF), 32'd10, 32'd0, 1'b1,
             exp_t'{2'b00, 32'd10, 32'hFFFFFFFF, 5'd6});
        send(mk_i(4'd5, 5'd7, 5'd1, 16'hFFFF), 32'd3, 32'd0, 1'b1,
             exp_t'{2'b01, 32'd3, 32'h0000FFFF, 5'd7});
        send(mk_r(4'd3, 5'd8, 5'd5, 5'd6), 32'd1, 32'd2, 1'b1, exp_t'{2'b11, 32'd1, 32'd2, 5'd8});
        fwd_valid = 1'b1; fwd_rd = 5'd4; fwd_data = 32'd99;
        send(mk_r(4'd2, 5'd9, 5'd4, 5'd2), 32'd1, 32'd8, 1'b1, exp_t'{2'b10, 32'd99, 32'd8, 5'd9});
        send(mk_r(4'd1, 5'd10, 5'd1, 5'd4), 32'd6, 32'd5, 1'b1, exp_t'{2'b01, 32'd6, 32'd99, 5'd10});
        send(mk_i(4'd4, 5'd11, 5'd1, 16'h8000), 32'd2, 32'd0, 1'b1,
             exp_t'{2'b00, 32'd2, 32'hFFFF8000, 5'd11});
        fwd_rd = 5'd0;
        send(mk_r(4'd2, 5'd12, 5'd0, 5'd3), 32'd1, 32'd4, 1'b1, exp_t'{2'b10, 32'd1, 32'd4, 5'd12});
        fwd_valid = 1'b0;
        idle(3);

        // Backpressure: third instruction held until the head drains
        out_ready = 1'b0;
        send(mk_r(4'd0, 5'd1, 5'd1, 5'd2), 32'd11, 32'd12, 1'b1, exp_t'{2'b00, 32'd11, 32'd12, 5'd1});
        send(mk_r(4'd2, 5'd2, 5'd1, 5'd2), 32'd21, 32'd22, 1'b1, exp_t'{2'b10, 32'd21, 32'd22, 5'd2});
        instr = mk_r(4'd1, 5'd3, 5'd1, 5'd2); rs_data = 32'd31; rt_data = 32'd32;
        #3;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("hold_a", A, 32'd11);
        @(posedge clk); #1;
        chk("hold_a_stable", A, 32'd11);
        chk("hold_rd_stable", 32'(rd), 32'd1);
        chk("full_in_ready_2", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(mk_r(4'd1, 5'd3, 5'd1, 5'd2), 32'd31, 32'd32, 1'b1, exp_t'{2'b01, 32'd31, 32'd32, 5'd3});
        idle(4);

        // Back-to-back throughput with both queues flowing
        for (int i = 0; i < 5; i++) begin
            send(mk_r(4'd0, 5'(i + 1), 5'd1, 5'd2), 32'(100 + i), 32'(200 + i), 1'b1,
                 exp_t'{2'b00, 32'(100 + i), 32'(200 + i), 5'(i + 1)});
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        idle(4);
        chk("drained_queue", 32'(expq.size()), 32'd0);

        // Flush with two entries buffered and an illegal opcode in flight
        out_ready = 1'b0;
        send(mk_r(4'd0, 5'd4, 5'd1, 5'd2), 32'd1, 32'd1, 1'b1, exp_t'{2'b00, 32'd1, 32'd1, 5'd4});
        send(mk_r(4'd0, 5'd5, 5'd1, 5'd2), 32'd2, 32'd2, 1'b1, exp_t'{2'b00, 32'd2, 32'd2, 5'd5});
        flush = 1'b1; out_ready = 1'b1; instr = 32'hF000_0000;
        #3;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        expq.delete();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_no_illegal", 32'(illegal_cnt), 32'd0);
        idle(2);

        // Illegal opcodes: counted, never issued, saturate at 255
        saw_valid = 1'b0;
        send(32'hF000_0000, 32'd0, 32'd0, 1'b0, exp_t'('0));
        in_valid = 1'b0;
        chk("illegal_cnt_one", 32'(illegal_cnt), 32'd1);
        in_valid = 1'b1; instr = 32'hF123_4567;
        for (int i = 0; i < 299; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        in_valid = 1'b0;
        chk("illegal_never_valid", 32'(saw_valid), 32'd0);
        chk("illegal_cnt_sat", 32'(illegal_cnt), 32'd255);
        idle(1);

        // Asynchronous reset between edges discards buffered entries
        out_ready = 1'b0;
        send(mk_r(4'd0, 5'd6, 5'd1, 5'd2), 32'd3, 32'd3, 1'b1, exp_t'{2'b00, 32'd3, 32'd3, 5'd6});
        send(mk_r(4'd0, 5'd7, 5'd1, 5'd2), 32'd4, 32'd4, 1'b1, exp_t'{2'b00, 32'd4, 32'd4, 5'd7});
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        expq.delete();
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_illegal_cnt", 32'(illegal_cnt), 32'd0);
        chk("async_a", A, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("async_ready_after", 32'(in_ready), 32'd1);
        chk("async_no_issue", 32'(out_valid), 32'd0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
